// File: rtl/irq_dispatch.sv
// irq_dispatch
//
// Interrupt dispatch sequencer for the SM83 core. When an enabled
// interrupt is pending at an instruction boundary and IME is set, it
// stalls the core, pushes PC (high byte first) through the memory write
// port while stepping SP down via the register file, then loads PC with
// the vector of the highest-priority (lowest-numbered) pending interrupt.
//
// Parameters:
//   VEC_BASE    vector address of interrupt bit 0
//   VEC_STRIDE  byte spacing between consecutive vectors
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   ie, if_in           interrupt enable / flag bits
//   ime                 interrupt master enable
//   fetch_boundary      one-cycle strobe, core is between instructions
//   halted              core is in HALT
//   r_pc, r_sp          current PC / SP from the register file
//   mem_ack             memory write accepted this cycle
//   core_hold           stall request, high in every non-IDLE state
//   wen_pc, w_pc        PC write enable / data into the register file
//   wen_sp, w_sp        SP write enable / data into the register file
//   mem_req, mem_addr,
//   mem_wdata           memory write request
//   if_clr              one-hot pulse clearing the serviced IF bit
//   ime_clr             pulse clearing IME
//   halt_exit           pulse releasing HALT

module irq_dispatch #(
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ie,
    input  logic [4:0]  if_in,
    input  logic        ime,
    input  logic        fetch_boundary,
    input  logic        halted,
    input  logic [15:0] r_pc,
    input  logic [15:0] r_sp,
    input  logic        mem_ack,
    output logic        core_hold,
    output logic        wen_pc,
    output logic [15:0] w_pc,
    output logic        wen_sp,
    output logic [15:0] w_sp,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [4:0]  if_clr,
    output logic        ime_clr,
    output logic        halt_exit
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SP1,
        PUSH_HI,
        PUSH_LO,
        JUMP
    } state_t;

    state_t      state;
    logic [15:0] pc_q;
    logic [15:0] vec_q;
    logic [4:0]  sel_q;
    logic        halt_done;

    logic [4:0]  pending;
    logic        any_pending;
    logic        trigger;
    logic [2:0]  pick_idx;
    logic [4:0]  pick_sel;
    logic [15:0] pick_vec;

    assign pending     = ie & if_in;
    assign any_pending = |pending;
    assign trigger     = (state == IDLE) & ime & any_pending & fetch_boundary;

    // Lowest set bit wins. With nothing pending the selection collapses to
    // zero so a dispatch cancelled mid-push jumps to 0000 and clears no flag.
    always_comb begin
        pick_idx = 3'd0;
        pick_sel = 5'b00000;
        casez (pending)
            5'b????1: begin pick_idx = 3'd0; pick_sel = 5'b00001; end
            5'b???10: begin pick_idx = 3'd1; pick_sel = 5'b00010; end
            5'b??100: begin pick_idx = 3'd2; pick_sel = 5'b00100; end
            5'b?1000: begin pick_idx = 3'd3; pick_sel = 5'b01000; end
            5'b10000: begin pick_idx = 3'd4; pick_sel = 5'b10000; end
            default:  begin pick_idx = 3'd0; pick_sel = 5'b00000; end
        endcase
        if (any_pending) begin
            pick_vec = VEC_BASE + 16'(pick_idx) * 16'(VEC_STRIDE);
        end else begin
            pick_vec = 16'h0000;
        end
    end

    // Sequencer state plus the values captured along the way: PC at the
    // start, and the vector/flag choice at the high-byte ack, which is the
    // last point where a late-cleared IE or IF can still cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc_q  <= 16'h0000;
            vec_q <= 16'h0000;
            sel_q <= 5'b00000;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) state <= LATCH;
                end
                LATCH: begin
                    pc_q  <= r_pc;
                    state <= SP1;
                end
                SP1: begin
                    state <= PUSH_HI;
                end
                PUSH_HI: begin
                    if (mem_ack) begin
                        vec_q <= pick_vec;
                        sel_q <= pick_sel;
                        state <= PUSH_LO;
                    end
                end
                PUSH_LO: begin
                    if (mem_ack) state <= JUMP;
                end
                JUMP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // HALT release pulse. halt_done remembers that this HALT episode has
    // already been released, so a long HALT with a steady pending bit
    // gives exactly one pulse until halted drops and rises again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_exit <= 1'b0;
            halt_done <= 1'b0;
        end else begin
            halt_exit <= halted & any_pending & ~halt_done;
            if (!halted) begin
                halt_done <= 1'b0;
            end else if (any_pending) begin
                halt_done <= 1'b1;
            end
        end
    end

    // Datapath outputs are decoded from the state rather than registered:
    // SP writes and push addresses must follow r_sp as it is this cycle,
    // which already holds the previous cycle's SP write.
    always_comb begin
        core_hold = 1'b0;
        wen_pc    = 1'b0;
        w_pc      = 16'h0000;
        wen_sp    = 1'b0;
        w_sp      = 16'h0000;
        mem_req   = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        if_clr    = 5'b00000;
        ime_clr   = 1'b0;
        case (state)
            LATCH: begin
                core_hold = 1'b1;
                ime_clr   = 1'b1;
            end
            SP1: begin
                core_hold = 1'b1;
                wen_sp    = 1'b1;
                w_sp      = r_sp - 16'd1;
            end
            PUSH_HI: begin
                core_hold = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = r_sp;
                mem_wdata = pc_q[15:8];
                if (mem_ack) begin
                    wen_sp = 1'b1;
                    w_sp   = r_sp - 16'd1;
                end
            end
            PUSH_LO: begin
                core_hold = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = r_sp;
                mem_wdata = pc_q[7:0];
            end
            JUMP: begin
                core_hold = 1'b1;
                wen_pc    = 1'b1;
                w_pc      = vec_q;
                if_clr    = sel_q;
            end
            default: begin
                core_hold = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_dispatch.sv
// tb_irq_dispatch
//
// Self-checking bench for irq_dispatch. A small register-file model
// closes the PC/SP loop, an ack generator inserts wait states, and a
// scoreboard holds the expected memory writes and PC jumps that the
// negedge monitor pops as the design produces them.

module tb_irq_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ie;
    logic [4:0]  if_in;
    logic        ime;
    logic        fetch_boundary;
    logic        halted;
    logic [15:0] r_pc;
    logic [15:0] r_sp;
    logic        mem_ack = 1'b0;
    logic        core_hold;
    logic        wen_pc;
    logic [15:0] w_pc;
    logic        wen_sp;
    logic [15:0] w_sp;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [4:0]  if_clr;
    logic        ime_clr;
    logic        halt_exit;

    irq_dispatch #(
        .VEC_BASE   (16'h0040),
        .VEC_STRIDE (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ie             (ie),
        .if_in          (if_in),
        .ime            (ime),
        .fetch_boundary (fetch_boundary),
        .halted         (halted),
        .r_pc           (r_pc),
        .r_sp           (r_sp),
        .mem_ack        (mem_ack),
        .core_hold      (core_hold),
        .wen_pc         (wen_pc),
        .w_pc           (w_pc),
        .wen_sp         (wen_sp),
        .w_sp           (w_sp),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .if_clr         (if_clr),
        .ime_clr        (ime_clr),
        .halt_exit      (halt_exit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [15:0] vec;
        logic [4:0]  sel;
    } jmp_t;

    wr_t  exp_wr[$];
    jmp_t exp_jump[$];

    int vectors     = 0;
    int miscompares = 0;

    int hold_cnt = 0;
    int ime_cnt  = 0;
    int halt_cnt = 0;
    int wr_cnt   = 0;
    int jump_cnt = 0;

    // Register file model: writes land on the clock edge, the bench can
    // preload PC/SP through load_req.
    logic        load_req = 1'b0;
    logic [15:0] load_pc  = 16'h0000;
    logic [15:0] load_sp  = 16'h0000;
    logic [15:0] pc_reg   = 16'h0000;
    logic [15:0] sp_reg   = 16'h0000;

    assign r_pc = pc_reg;
    assign r_sp = sp_reg;

    always @(posedge clk) begin
        if (load_req) begin
            pc_reg <= load_pc;
            sp_reg <= load_sp;
        end else begin
            if (wen_pc) pc_reg <= w_pc;
            if (wen_sp) sp_reg <= w_sp;
        end
    end

    // Ack generator: each request sees ack_delay low cycles before ack.
    int ack_delay = 0;
    int wait_cnt  = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (mem_ack) wait_cnt = 0;
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Monitor: samples on the falling edge, checks every pending write
    // against the scoreboard head and every PC jump against its entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (core_hold) hold_cnt = hold_cnt + 1;
            if (ime_clr)   ime_cnt  = ime_cnt + 1;
            if (halt_exit) halt_cnt = halt_cnt + 1;
            if (mem_req) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write", 32'(mem_req), 32'd0);
                end else begin
                    checkOutput("wr_addr", 32'(mem_addr), 32'(exp_wr[0].addr));
                    checkOutput("wr_data", 32'(mem_wdata), 32'(exp_wr[0].data));
                    if (mem_ack) begin
                        void'(exp_wr.pop_front());
                        wr_cnt = wr_cnt + 1;
                    end
                end
            end
            if (wen_pc) begin
                jump_cnt = jump_cnt + 1;
                if (exp_jump.size() == 0) begin
                    checkOutput("unexpected_jump", 32'(wen_pc), 32'd0);
                end else begin
                    jmp_t j;
                    j = exp_jump.pop_front();
                    checkOutput("w_pc", 32'(w_pc), 32'(j.vec));
                    checkOutput("if_clr", 32'(if_clr), 32'(j.sel));
                end
            end else if (if_clr != 5'b00000) begin
                checkOutput("stray_if_clr", 32'(if_clr), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic loadRegs(input logic [15:0] pc, input logic [15:0] sp);
        load_pc  = pc;
        load_sp  = sp;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (core_hold && n < 60) begin
            tick(1);
            n = n + 1;
        end
        checkOutput("idle_timeout", 32'(core_hold), 32'd0);
        tick(2);
    endtask

    // Reference priority pick: lowest pending bit, vector 0x40 + 8*n.
    function automatic jmp_t expectedJump(input logic [4:0] pend);
        jmp_t j;
        j.vec = 16'h0000;
        j.sel = 5'b00000;
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) begin
                j.sel = 5'b00001 << i;
                j.vec = 16'h0040 + 16'(i * 8);
            end
        end
        return j;
    endfunction

    task automatic applyStimulus(input string tag, input logic [4:0] ie_v,
                                 input logic [4:0] if_v, input logic [15:0] pc,
                                 input logic [15:0] sp, input int delay,
                                 input logic cancel, input logic with_halt);
        wr_t  w;
        jmp_t j;
        int   h0, i0, w0, j0, x0;
        $display("[TB] dispatch %s", tag);
        loadRegs(pc, sp);
        ie        = ie_v;
        if_in     = if_v;
        ime       = 1'b1;
        ack_delay = delay;
        w.addr = sp - 16'd1;
        w.data = pc[15:8];
        exp_wr.push_back(w);
        w.addr = sp - 16'd2;
        w.data = pc[7:0];
        exp_wr.push_back(w);
        j = expectedJump(cancel ? 5'b00000 : (ie_v & if_v));
        exp_jump.push_back(j);
        h0 = hold_cnt;
        i0 = ime_cnt;
        w0 = wr_cnt;
        j0 = jump_cnt;
        x0 = halt_cnt;
        halted         = with_halt;
        fetch_boundary = 1'b1;
        tick(1);
        fetch_boundary = 1'b0;
        if (cancel) ie = 5'b00000;
        checkOutput({tag, "_enter"}, 32'({halt_exit, core_hold}),
                    32'({with_halt, 1'b1}));
        waitIdle();
        checkOutput({tag, "_hold_cycles"}, 32'(hold_cnt - h0), 32'(5 + 2 * delay));
        checkOutput({tag, "_ime_clr"}, 32'(ime_cnt - i0), 32'd1);
        checkOutput({tag, "_writes"}, 32'(wr_cnt - w0), 32'd2);
        checkOutput({tag, "_jumps"}, 32'(jump_cnt - j0), 32'd1);
        checkOutput({tag, "_halt_exit"}, 32'(halt_cnt - x0), 32'(with_halt));
        checkOutput({tag, "_pc"}, 32'(pc_reg), 32'(j.vec));
        checkOutput({tag, "_sp"}, 32'(sp_reg), 32'(16'(sp - 16'd2)));
        checkOutput({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        checkOutput({tag, "_jump_left"}, 32'(exp_jump.size()), 32'd0);
        halted = 1'b0;
        tick(1);
    endtask

    initial begin
        int h0, w0, j0, x0, n;
        wr_t  w;
        jmp_t j;

        rst_n          = 1'b1;
        ie             = 5'b00000;
        if_in          = 5'b00000;
        ime            = 1'b0;
        fetch_boundary = 1'b0;
        halted         = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        checkOutput("reset_ctrl", 32'({core_hold, wen_pc, wen_sp, mem_req, ime_clr,
                    halt_exit, if_clr}), 32'd0);
        checkOutput("reset_w_pc", 32'(w_pc), 32'd0);
        checkOutput("reset_w_sp", 32'(w_sp), 32'd0);
        checkOutput("reset_mem", 32'({mem_addr, mem_wdata}), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        applyStimulus("basic",    5'h01, 5'h01, 16'h1234, 16'hFFFE, 0, 1'b0, 1'b0);
        applyStimulus("priority", 5'h1F, 5'h14, 16'h4321, 16'hD000, 0, 1'b0, 1'b0);
        applyStimulus("cancel",   5'h04, 5'h04, 16'h5678, 16'hC000, 0, 1'b1, 1'b0);
        applyStimulus("wrap",     5'h08, 5'h08, 16'hABCD, 16'h0001, 3, 1'b0, 1'b0);

        // HALT with IME clear: one release pulse, no dispatch.
        $display("[TB] halt with ime=0");
        ime   = 1'b0;
        ie    = 5'h02;
        if_in = 5'h02;
        h0 = hold_cnt;
        w0 = wr_cnt;
        x0 = halt_cnt;
        halted = 1'b1;
        tick(1);
        checkOutput("halt_pulse_high", 32'(halt_exit), 32'd1);
        fetch_boundary = 1'b1;
        tick(1);
        fetch_boundary = 1'b0;
        checkOutput("halt_pulse_low", 32'(halt_exit), 32'd0);
        tick(6);
        checkOutput("halt_count", 32'(halt_cnt - x0), 32'd1);
        checkOutput("halt_no_hold", 32'(hold_cnt - h0), 32'd0);
        checkOutput("halt_no_write", 32'(wr_cnt - w0), 32'd0);
        halted = 1'b0;
        tick(2);
        halted = 1'b1;
        tick(5);
        checkOutput("halt_repulse", 32'(halt_cnt - x0), 32'd2);
        halted = 1'b0;
        tick(2);

        applyStimulus("halt_trig", 5'h10, 5'h10, 16'h0100, 16'hD000, 0, 1'b0, 1'b1);

        // Reset in the middle of the low-byte push.
        $display("[TB] reset mid-op");
        loadRegs(16'h2222, 16'h8000);
        ie        = 5'h01;
        if_in     = 5'h01;
        ime       = 1'b1;
        ack_delay = 3;
        w.addr = 16'h7FFF;
        w.data = 8'h22;
        exp_wr.push_back(w);
        w.addr = 16'h7FFE;
        exp_wr.push_back(w);
        j = expectedJump(5'h01);
        exp_jump.push_back(j);
        fetch_boundary = 1'b1;
        tick(1);
        fetch_boundary = 1'b0;
        n = 0;
        while (!(mem_req && exp_wr.size() == 1) && n < 40) begin
            tick(1);
            n = n + 1;
        end
        checkOutput("reach_push_lo", 32'(mem_addr), 32'h7FFE);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midop_ctrl", 32'({core_hold, wen_pc, wen_sp, mem_req, ime_clr,
                    halt_exit, if_clr}), 32'd0);
        checkOutput("midop_w_pc", 32'(w_pc), 32'd0);
        checkOutput("midop_w_sp", 32'(w_sp), 32'd0);
        checkOutput("midop_mem", 32'({mem_addr, mem_wdata}), 32'd0);
        exp_wr.delete();
        exp_jump.delete();
        tick(2);
        rst_n = 1'b1;
        h0 = hold_cnt;
        w0 = wr_cnt;
        j0 = jump_cnt;
        tick(8);
        checkOutput("post_reset_hold", 32'(hold_cnt - h0), 32'd0);
        checkOutput("post_reset_writes", 32'(wr_cnt - w0), 32'd0);
        checkOutput("post_reset_jumps", 32'(jump_cnt - j0), 32'd0);

        applyStimulus("after_reset", 5'h03, 5'h02, 16'h9ABC, 16'h8000, 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
